// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single write port of the 32x64 register file among NREQ
// writeback requesters. Round-robin grant with a valid/ready handshake,
// one registered write stage, and x0 writes acknowledged but not committed.
// Optional feature macro: REGFILE_WB_FWD_EN adds a two-port forwarding view
// of the write currently on write_* so readers can bypass the register file.
module regfile_wb_arbiter #(
    parameter int WORDSIZE = 64,
    parameter int NREQ     = 2,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*5-1:0]        req_addr,
    input  logic [NREQ*WORDSIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wb_stall,
    output logic                     write_en,
    output logic [4:0]               write_addr,
    output logic [WORDSIZE-1:0]      write_data,
    output logic [1:0]               grant_id,
`ifdef REGFILE_WB_FWD_EN
    input  logic [4:0]               fwd_addr_a,
    input  logic [4:0]               fwd_addr_b,
    output logic                     fwd_hit_a,
    output logic                     fwd_hit_b,
    output logic [WORDSIZE-1:0]      fwd_data_a,
    output logic [WORDSIZE-1:0]      fwd_data_b,
`endif
    output logic [CNT_W-1:0]         wr_count
);

    // Round-robin pointer: index of the most recently granted requester.
    logic [1:0]          last;
    logic [1:0]          winner;
    logic                found;
    logic                accept;
    int                  idx;
    logic [4:0]          win_addr;
    logic [WORDSIZE-1:0] win_data;

    // Search from last+1 upward with wrap; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[1:0];
            end
        end
    end

    // Grant is suppressed during reset and stall; ready is one-hot or zero.
    always_comb begin
        accept    = reset && !wb_stall && found;
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
        win_addr = req_addr[int'(winner)*5 +: 5];
        win_data = req_data[int'(winner)*WORDSIZE +: WORDSIZE];
    end

    // Write stage: capture the accepted request; x0 is acknowledged but not written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_en   <= 1'b0;
            write_addr <= 5'd0;
            write_data <= '0;
            grant_id   <= 2'd0;
            wr_count   <= '0;
            last       <= 2'(NREQ - 1);
        end else begin
            wr_count <= wr_count + CNT_W'(write_en);
            write_en <= 1'b0;
            if (accept) begin
                write_en   <= (win_addr != 5'd0);
                write_addr <= win_addr;
                write_data <= win_data;
                grant_id   <= winner;
                last       <= winner;
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Bypass: expose the value committing this cycle ahead of the register file.
    always_comb begin
        fwd_hit_a  = write_en && (write_addr == fwd_addr_a);
        fwd_hit_b  = write_en && (write_addr == fwd_addr_b);
        fwd_data_a = fwd_hit_a ? write_data : '0;
        fwd_data_b = fwd_hit_b ? write_data : '0;
    end
`endif

endmodule
